// File: rtl/ex_muldiv_ctrl.sv
// RV32M multiply/divide sequencer for the EX stage: shift-add multiply and
// restoring divide, one iteration per cycle, with a one-cycle md_done pulse.
module ex_muldiv_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_muldiv,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall_req,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam int unsigned ACC_W = 2 * XLEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;

    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [XLEN-1:0]  opnd;
    logic [ACC_W-1:0] acc;
    logic             neg_q, neg_r;

    logic             start, load, step, last_iter;
    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  a_mag, b_mag, special_res;
    logic [XLEN:0]    mul_sum, div_trial, div_diff;
    logic             div_ge;
    logic [ACC_W-1:0] acc_step, prod_fix;
    logic [XLEN-1:0]  quo, rem, calc_res;

    // Issue-time decode: operand magnitudes, sign flags and RISC-V special cases
    always_comb begin
        start    = ex_valid & ex_is_muldiv & ~flush;
        is_div   = funct3[2];
        a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = is_div ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & rs1[XLEN-1];
        b_neg    = b_signed & rs2[XLEN-1];
        a_mag    = a_neg ? (~rs1 + XLEN'(1)) : rs1;
        b_mag    = b_neg ? (~rs2 + XLEN'(1)) : rs2;
        div_zero = is_div & (rs2 == '0);
        div_ovf  = is_div & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = funct3[1] ? rs1 : ALL_ONES;
        end else begin
            special_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_trial = {acc[ACC_W-1:XLEN], acc[XLEN-1]};
        div_diff  = div_trial - {1'b0, opnd};
        div_ge    = ~div_diff[XLEN];
        if (op[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Sign-corrected result from the final iteration's accumulator
    always_comb begin
        prod_fix = neg_q ? (~acc_step + ACC_W'(1)) : acc_step;
        quo      = acc_step[XLEN-1:0];
        rem      = acc_step[ACC_W-1:XLEN];
        case (op)
            F_MUL:                      calc_res = prod_fix[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  calc_res = prod_fix[ACC_W-1:XLEN];
            F_DIV, F_DIVU:              calc_res = neg_q ? (~quo + XLEN'(1)) : quo;
            default:                    calc_res = neg_r ? (~rem + XLEN'(1)) : rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        md_done   = 1'b0;
        last_iter = (cnt == CNT_LAST);
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                stall_req = start & ~rst;
                load      = start;
                if (start) begin
                    state_nxt = special ? DONE : CALC;
                end
            end
            CALC: begin
                stall_req = 1'b1;
                step      = ~flush;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                md_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A flush kills the instruction in any state
        if (flush) begin
            state_nxt = IDLE;
            stall_req = 1'b0;
            md_done   = 1'b0;
        end
    end

    // Operand/accumulator datapath; md_result updates only on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            op        <= '0;
            opnd      <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            md_result <= '0;
        end else if (load) begin
            cnt   <= '0;
            op    <= funct3;
            opnd  <= is_div ? b_mag : a_mag;
            acc   <= is_div ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) begin
                md_result <= special_res;
            end
        end else if (step) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                md_result <= calc_res;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: directed vector table, multi-cycle corner sequences
// and random ops checked against a plain-arithmetic RV32M reference.
module tb_ex_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_is_muldiv;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall_req;
    logic        md_done;
    logic [31:0] md_result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] last_res = '0;

    localparam logic [31:0] MIN32 = 32'h8000_0000;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;

    ex_muldiv_ctrl #(.XLEN(32), .ITERS(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_is_muldiv (ex_is_muldiv),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .flush        (flush),
        .stall_req    (stall_req),
        .md_done      (md_done),
        .md_result    (md_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ua = longint'(a);
        logic [63:0] p;
        logic [31:0] r;
        case (f3)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(b)); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: r = (b == 0) ? ONES : (a == MIN32 && b == ONES) ? MIN32 : 32'(sa / sb);
            3'd5: r = (b == 0) ? ONES : a / b;
            3'd6: r = (b == 0) ? a : (a == MIN32 && b == ONES) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        if (ua < 0) r = '0;
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == MIN32 && b == ONES))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return MIN32;
            2: return ONES;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one op at the current cycle start, hold it until md_done, then leave one cycle later
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string nm,
                          output int done_cyc);
        int  stalls = 0;
        int  lat    = 0;
        bit  seen   = 1'b0;
        ex_valid = 1'b1; ex_is_muldiv = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
        done_cyc = 0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (md_done) begin
                seen = 1'b1;
                lat = c;
                done_cyc = cyc;
                chk({nm, "_stall_at_done"}, 32'(stall_req), 32'd0);
                break;
            end
            if (stall_req) stalls++;
            @(posedge clk); #1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_stalls"}, 32'(stalls), 32'(exp_lat));
        chk({nm, "_result"}, md_result, exp_res);
        last_res = exp_res;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_muldiv = 1'b0;
    endtask

    initial begin
        int d0, d1, ndone, gap;
        logic [2:0]  f3;
        logic [31:0] a, b;

        tbl[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, MIN32,        MIN32,         32'h4000_0000, 33};
        tbl[2]  = '{3'd3, ONES,         ONES,          32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, ONES,         ONES,          32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
        tbl[6]  = '{3'd5, 32'd100,      32'd7,         32'd14,        33};
        tbl[7]  = '{3'd7, 32'd100,      32'd7,         32'd2,         33};
        tbl[8]  = '{3'd5, 32'h1234,     32'd0,         ONES,          1};
        tbl[9]  = '{3'd6, 32'h1234,     32'd0,         32'h1234,      1};
        tbl[10] = '{3'd4, MIN32,        ONES,          MIN32,         1};
        tbl[11] = '{3'd6, MIN32,        ONES,          32'd0,         1};
        tbl[12] = '{3'd5, MIN32,        ONES,          32'd0,         33};
        tbl[13] = '{3'd0, 32'd3,        32'd5,         32'd15,        33};
        tbl[14] = '{3'd4, 32'd5,        32'd0,         ONES,          1};

        rst = 1'b1; ex_valid = 1'b0; ex_is_muldiv = 1'b0; funct3 = '0;
        rs1 = '0; rs2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", 32'(stall_req), 32'd0);
        chk("reset_done", 32'(md_done), 32'd0);
        chk("reset_result", md_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat,
                   $sformatf("vec%0d", i), d0);
        end

        // Non-start cycles: flushed issue, not an M op, not valid
        ex_valid = 1'b1; ex_is_muldiv = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
        flush = 1'b1;
        #1 chk("flush_issue_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; ex_is_muldiv = 1'b0;
        #1 chk("not_muldiv_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_is_muldiv = 1'b1;
        #1 chk("not_valid_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;

        // Flush at iteration 10 of a multiply
        ex_valid = 1'b1; ex_is_muldiv = 1'b1; funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
        end
        #1 chk("calc_stall_before_flush", 32'(stall_req), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush_calc_stall", 32'(stall_req), 32'd0);
        chk("flush_calc_done", 32'(md_done), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            #1 if (md_done) ndone++;
            @(posedge clk); #1;
        end
        chk("flush_no_done", 32'(ndone), 32'd0);
        chk("flush_result_held", md_result, last_res);
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 33, "mul_after_flush", d0);

        // Reset pulse mid-CALC with the op still presented
        ex_valid = 1'b1; ex_is_muldiv = 1'b1; funct3 = 3'd0; rs1 = 32'd6; rs2 = 32'd7;
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("midreset_stall", 32'(stall_req), 32'd0);
        chk("midreset_done", 32'(md_done), 32'd0);
        chk("midreset_result", md_result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; ex_valid = 1'b0; ex_is_muldiv = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            #1 if (md_done) ndone++;
            @(posedge clk); #1;
        end
        chk("midreset_no_done", 32'(ndone), 32'd0);

        // Back-to-back multiplies
        run_op(3'd0, 32'd2, 32'd3, 32'd6, 33, "b2b_first", d0);
        run_op(3'd0, 32'd4, 32'd5, 32'd20, 33, "b2b_second", d1);
        chk("b2b_spacing", 32'(d1 - d0), 32'd34);

        // Random ops against the reference model, with idle/non-start gaps
        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                case ($urandom_range(0, 2))
                    0: begin ex_valid = 1'b0; ex_is_muldiv = 1'b1; end
                    1: begin ex_valid = 1'b1; ex_is_muldiv = 1'b0; end
                    default: begin ex_valid = 1'b1; ex_is_muldiv = 1'b1; flush = 1'b1; end
                endcase
                #1;
                chk("rand_gap_stall", 32'(stall_req), 32'd0);
                chk("rand_gap_done", 32'(md_done), 32'd0);
                @(posedge clk); #1;
                flush = 1'b0;
            end
            f3 = 3'($urandom_range(0, 7));
            a  = rnd_opnd();
            b  = rnd_opnd();
            run_op(f3, a, b, ref_md(f3, a, b), ref_lat(f3, a, b),
                   $sformatf("rand%0d_f%0d_%h_%h", n, f3, a, b), d0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
Multi-cycle sequencer for RV32M multiply/divide in the EX stage. It accepts an M-extension op from EX and stalls the pipeline while a shift-add multiplier or restoring divider iterates. It then presents a registered result for one cycle, and EX muxes that result onto its ALU output path.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITERS, 32, iteration cycles for multiply and divide; must equal XLEN.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
ex_valid  input  1  EX holds a valid instruction this cycle.
ex_is_muldiv  input  1  EX instruction is an M-extension op.
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  input  XLEN  operand A (dividend / multiplicand).
rs2  input  XLEN  operand B (divisor / multiplier).
flush  input  1  kill the EX instruction; aborts any operation.
stall_req  output  1  freeze IF/ID/EX and insert a bubble into MEM.
md_done  output  1  md_result is valid this cycle.
md_result  output  XLEN  final result.

Behaviour:
- Reset (async, rst=1): state=IDLE, iteration counter=0, all internal regs=0, stall_req=0, md_done=0, md_result=0.
- States: IDLE, CALC, DONE.
- Start condition is start = ex_valid & ex_is_muldiv & ~flush, and is sampled only in IDLE.
- IDLE:
  - stall_req = start (combinational), so the issue cycle itself is stalled.
  - On start: latch funct3 and the operand magnitudes. Signed ops take abs(); MULHSU takes abs of rs1 only.
  - Also latch result-sign flags and clear the counter.
  - Next state is DONE if the op is a divide-by-zero or a signed overflow, otherwise CALC.
- CALC:
  - stall_req=1.
  - One iteration per cycle: shift-add multiply over a 64-bit accumulator, or restoring divide producing one quotient bit per cycle.
  - Counter increments each cycle. After ITERS iterations (counter==ITERS-1), register the sign-corrected md_result and go to DONE.
- DONE:
  - stall_req=0, md_done=1; the pipeline advances this cycle.
  - ex_is_muldiv, which is still high for the same instruction, is ignored.
  - Unconditional transition to IDLE.
- Latency for a normal op issued in cycle N: stalled cycles N..N+32 (33 cycles); md_done=1 in cycle N+33.
- Latency for a special-case op: stalled in cycle N only; md_done=1 in N+1.
- md_result is held after DONE until the next completion. md_done is a single-cycle pulse.
- Result selection:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits, sign-corrected via the 64-bit two's complement of the product when the sign flag is set.
  - DIV/DIVU: quotient, negated if the signs differ (signed only).
  - REM/REMU: remainder, with the sign of the dividend (signed only).
- Special cases (RISC-V spec):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=rs1.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Flush: in any state, flush=1 gives next state=IDLE, forces stall_req=0 that cycle, and suppresses md_done. An issue cycle that has flush high does not start.
- Back-to-back M ops: the cycle after DONE is IDLE, and a new start there is accepted normally.
- ex_valid=0 or ex_is_muldiv=0 in IDLE: no action, stall_req=0.
- Reset asserted mid-CALC: immediate return to reset values; no md_done.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD issued cycle N -> stall_req high N..N+32; md_done in N+33 with md_result=0xFFFFFFEB; stall_req=0 in N+33.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU x/0 -> 0xFFFFFFFF and REM x/0 -> x, each with one stall cycle. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done at N+1.
- Flush at CALC iteration 10 -> stall_req=0 that cycle, IDLE next, no md_done. A subsequent MUL 3*5 -> 15 with full latency.
- rst pulse mid-CALC -> outputs 0 immediately. Two back-to-back MULs 2*3 then 4*5 -> md_done pulses 34 cycles apart with results 6 then 20.
